// File: rtl/muldiv_seq_r32m.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : muldiv_seq_r32m                                                 |
// | Purpose  : Iterative radix-2 RV32M multiply/divide unit with valid/ready   |
// |            handshakes (shift-add multiply, restoring divide, sign fix-up). |
// | Option   : MULDIV_EARLY_OUT_EN - divide special cases finish in one cycle. |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module muldiv_seq_r32m #(
   parameter int DATA_W = 32
) (
   input  logic              clock,
   input  logic              nReset,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [2:0]        op,
   input  logic [DATA_W-1:0] A,
   input  logic [DATA_W-1:0] B,
   input  logic              flush,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [DATA_W-1:0] result
);

   localparam int                c_CNT_W    = $clog2(DATA_W);
   localparam logic [c_CNT_W-1:0] c_CNT_LAST = c_CNT_W'(DATA_W - 1);
   localparam logic [c_CNT_W-1:0] c_CNT_ONE  = c_CNT_W'(1);
   localparam logic [DATA_W-1:0] c_ONE      = {{(DATA_W-1){1'b0}}, 1'b1};
   localparam logic [DATA_W-1:0] c_MIN      = {1'b1, {(DATA_W-1){1'b0}}};

   localparam logic [1:0] c_S_IDLE = 2'd0;
   localparam logic [1:0] c_S_CALC = 2'd1;
   localparam logic [1:0] c_S_FIX  = 2'd2;
   localparam logic [1:0] c_S_DONE = 2'd3;

`ifdef MULDIV_EARLY_OUT_EN
   localparam logic c_EARLY = 1'b1;
`else
   localparam logic c_EARLY = 1'b0;
`endif

   logic [1:0]          state_q, state_d;
   logic [c_CNT_W-1:0]  cnt_q, cnt_d;
   logic [2:0]          op_q, op_d;
   logic [DATA_W-1:0]   hi_q, hi_d;
   logic [DATA_W-1:0]   lo_q, lo_d;
   logic [DATA_W-1:0]   b_q, b_d;
   logic                neg_a_q, neg_a_d;
   logic                neg_b_q, neg_b_d;
   logic                spec_q, spec_d;
   logic [DATA_W-1:0]   spec_res_q, spec_res_d;
   logic [DATA_W-1:0]   result_q, result_d;

   logic                w_accept;
   logic                w_sgn_a, w_sgn_b;
   logic                w_neg_a, w_neg_b;
   logic [DATA_W-1:0]   w_mag_a, w_mag_b;
   logic                w_b_zero, w_b_one, w_ovf;
   logic                w_spec;
   logic [DATA_W-1:0]   w_spec_res;
   logic [DATA_W:0]     w_sum;
   logic [DATA_W:0]     w_shift, w_diff;
   logic [2*DATA_W-1:0] w_prod, w_prod_s;
   logic [DATA_W-1:0]   w_quo, w_rem_s;
   logic [DATA_W-1:0]   w_fix_res;

   // flush wins over a pending request, so a request seen with flush is dropped
   assign w_accept = in_valid & in_ready & ~flush;

   // Operand decode: signedness per funct3, magnitudes for the unsigned core
   always_comb begin
      if (op[2]) begin
         w_sgn_a = ~op[0];
         w_sgn_b = ~op[0];
      end else begin
         w_sgn_a = (op[1:0] == 2'b01) || (op[1:0] == 2'b10);
         w_sgn_b = (op[1:0] == 2'b01);
      end
      w_neg_a = w_sgn_a & A[DATA_W-1];
      w_neg_b = w_sgn_b & B[DATA_W-1];
      w_mag_a = w_neg_a ? -A : A;
      w_mag_b = w_neg_b ? -B : B;
   end

   assign w_b_zero = (B == '0);
   assign w_b_one  = (B == c_ONE);
   assign w_ovf    = ~op[0] & (A == c_MIN) & (B == '1);

`ifdef MULDIV_EARLY_OUT_EN
   assign w_spec = op[2] & (w_b_zero | w_ovf | w_b_one);
`else
   assign w_spec = op[2] & w_b_zero;
`endif

   // Architectural results of the divide corner cases, from the raw operands
   assign w_spec_res = w_b_zero ? (op[1] ? A : '1) : (op[1] ? '0 : A);

   assign w_sum   = {1'b0, hi_q} + (lo_q[0] ? {1'b0, b_q} : '0);
   assign w_shift = {hi_q, lo_q[DATA_W-1]};
   assign w_diff  = w_shift - {1'b0, b_q};

   always_comb begin
      w_prod   = {hi_q, lo_q};
      w_prod_s = (neg_a_q ^ neg_b_q) ? -w_prod : w_prod;
      w_quo    = (neg_a_q ^ neg_b_q) ? -lo_q : lo_q;
      w_rem_s  = neg_a_q ? -hi_q : hi_q;
      if (spec_q) begin
         w_fix_res = spec_res_q;
      end else if (op_q[2]) begin
         w_fix_res = op_q[1] ? w_rem_s : w_quo;
      end else if (op_q[1:0] == 2'b00) begin
         w_fix_res = w_prod_s[DATA_W-1:0];
      end else begin
         w_fix_res = w_prod_s[2*DATA_W-1:DATA_W];
      end
   end

   // FSM: state register
   always_ff @(posedge clock or negedge nReset) begin
      if (!nReset) begin
         state_q <= c_S_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // FSM: next state
   always_comb begin
      state_d = state_q;
      if (flush) begin
         state_d = c_S_IDLE;
      end else begin
         case (state_q)
            c_S_IDLE: if (in_valid) state_d = (c_EARLY & w_spec) ? c_S_FIX : c_S_CALC;
            c_S_CALC: if (cnt_q == '0) state_d = c_S_FIX;
            c_S_FIX:  state_d = c_S_DONE;
            c_S_DONE: if (out_ready) state_d = c_S_IDLE;
            default:  state_d = c_S_IDLE;
         endcase
      end
   end

   // FSM: outputs
   always_comb begin
      in_ready  = (state_q == c_S_IDLE);
      out_valid = (state_q == c_S_DONE);
   end

   assign result = result_q;

   // Datapath: hi/lo act as product {hi,lo} or as {remainder, quotient}
   always_comb begin
      cnt_d      = cnt_q;
      op_d       = op_q;
      hi_d       = hi_q;
      lo_d       = lo_q;
      b_d        = b_q;
      neg_a_d    = neg_a_q;
      neg_b_d    = neg_b_q;
      spec_d     = spec_q;
      spec_res_d = spec_res_q;
      result_d   = result_q;
      if (w_accept) begin
         op_d       = op;
         neg_a_d    = w_neg_a;
         neg_b_d    = w_neg_b;
         hi_d       = '0;
         lo_d       = op[2] ? w_mag_a : w_mag_b;
         b_d        = op[2] ? w_mag_b : w_mag_a;
         cnt_d      = c_CNT_LAST;
         spec_d     = w_spec;
         spec_res_d = w_spec_res;
      end else if (state_q == c_S_CALC) begin
         cnt_d = cnt_q - c_CNT_ONE;
         if (op_q[2]) begin
            hi_d = w_diff[DATA_W] ? w_shift[DATA_W-1:0] : w_diff[DATA_W-1:0];
            lo_d = {lo_q[DATA_W-2:0], ~w_diff[DATA_W]};
         end else begin
            hi_d = w_sum[DATA_W:1];
            lo_d = {w_sum[0], lo_q[DATA_W-1:1]};
         end
      end else if ((state_q == c_S_FIX) && !flush) begin
         result_d = w_fix_res;
      end
   end

   always_ff @(posedge clock or negedge nReset) begin
      if (!nReset) begin
         cnt_q      <= '0;
         op_q       <= '0;
         hi_q       <= '0;
         lo_q       <= '0;
         b_q        <= '0;
         neg_a_q    <= 1'b0;
         neg_b_q    <= 1'b0;
         spec_q     <= 1'b0;
         spec_res_q <= '0;
         result_q   <= '0;
      end else begin
         cnt_q      <= cnt_d;
         op_q       <= op_d;
         hi_q       <= hi_d;
         lo_q       <= lo_d;
         b_q        <= b_d;
         neg_a_q    <= neg_a_d;
         neg_b_q    <= neg_b_d;
         spec_q     <= spec_d;
         spec_res_q <= spec_res_d;
         result_q   <= result_d;
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_muldiv_seq_r32m.sv
`default_nettype none
// Testbench for muldiv_seq_r32m (DATA_W=32): directed RV32M cases plus
// randomized operations checked against an arithmetic reference model.
module tb_muldiv_seq_r32m;

   logic        clock;
   logic        nReset;
   logic        in_valid;
   logic        in_ready;
   logic [2:0]  op;
   logic [31:0] A;
   logic [31:0] B;
   logic        flush;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] result;

   int n_assert = 0;
   int n_fail   = 0;
   logic [31:0] last_exp = '0;

   muldiv_seq_r32m #(.DATA_W(32)) dut (
      .clock     (clock),
      .nReset    (nReset),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .op        (op),
      .A         (A),
      .B         (B),
      .flush     (flush),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .result    (result)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   // RV32M semantics from plain 64-bit arithmetic
   function automatic logic [31:0] ref_model(input logic [2:0] o, input logic [31:0] a,
                                             input logic [31:0] b);
      longint          sa, sb;
      longint unsigned ua, ub;
      logic [63:0]     p;
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      ua = {32'b0, a};
      ub = {32'b0, b};
      p  = '0;
      case (o)
         3'd0: p = ua * ub;
         3'd1: p = 64'(sa * sb) >> 32;
         3'd2: p = 64'(sa * longint'(ub)) >> 32;
         3'd3: p = (ua * ub) >> 32;
         3'd4: begin
            if (b == 32'd0) p = 64'hFFFF_FFFF;
            else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) p = {32'b0, a};
            else p = 64'(sa / sb);
         end
         3'd5: p = (b == 32'd0) ? 64'hFFFF_FFFF : (ua / ub);
         3'd6: begin
            if (b == 32'd0) p = {32'b0, a};
            else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) p = '0;
            else p = 64'(sa % sb);
         end
         default: p = (b == 32'd0) ? {32'b0, a} : (ua % ub);
      endcase
      return p[31:0];
   endfunction

   function automatic int exp_latency(input logic [2:0] o, input logic [31:0] a,
                                      input logic [31:0] b);
`ifdef MULDIV_EARLY_OUT_EN
      if (o[2] && (b == 32'd0 || b == 32'd1 ||
                   (!o[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF)))
         return 1;
`endif
      return 33;
   endfunction

   function automatic logic [31:0] pick();
      case ($urandom_range(0, 7))
         0: return 32'd0;
         1: return 32'd1;
         2: return 32'hFFFF_FFFF;
         3: return 32'h8000_0000;
         4: return 32'($urandom_range(0, 20));
         default: return 32'($urandom());
      endcase
   endfunction

   task automatic run_op(input string tag, input logic [2:0] o, input logic [31:0] a,
                         input logic [31:0] b, input int hold);
      logic [31:0] exp;
      int          lat;
      int          n;
      exp = ref_model(o, a, b);
      lat = exp_latency(o, a, b);
      check({tag, "_ready_idle"}, in_ready, 1);
      op = o; A = a; B = b; in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
      op = 3'($urandom()); A = $urandom(); B = $urandom();
      check({tag, "_ready_busy"}, in_ready, 0);
      n = 0;
      while (!out_valid && n < 100) begin
         tick();
         n++;
      end
      check({tag, "_latency"}, n, lat);
      check({tag, "_result"}, result, exp);
      for (int i = 0; i < hold; i++) begin
         tick();
         check({tag, "_hold_valid"}, out_valid, 1);
         check({tag, "_hold_result"}, result, exp);
         check({tag, "_hold_ready"}, in_ready, 0);
      end
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
      check({tag, "_hs_valid"}, out_valid, 0);
      check({tag, "_hs_ready"}, in_ready, 1);
      last_exp = exp;
   endtask

   initial begin
      logic seen;
      nReset = 1'b0; in_valid = 1'b0; op = '0; A = '0; B = '0;
      flush = 1'b0; out_ready = 1'b0;
      tick(); tick();
      check("rst_in_ready", in_ready, 1);
      check("rst_out_valid", out_valid, 0);
      check("rst_result", result, 0);
      nReset = 1'b1;
      tick();

      run_op("mul_7_m3",    3'd0, 32'd7, 32'hFFFF_FFFD, 0);
      run_op("mulh_7_m3",   3'd1, 32'd7, 32'hFFFF_FFFD, 0);
      run_op("mulhu_max",   3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0);
      run_op("mulhsu_m1",   3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0);
      run_op("div_m7_2",    3'd4, 32'hFFFF_FFF9, 32'd2, 0);
      run_op("rem_m7_2",    3'd6, 32'hFFFF_FFF9, 32'd2, 0);
      run_op("divu_100_7",  3'd5, 32'd100, 32'd7, 0);
      run_op("remu_100_7",  3'd7, 32'd100, 32'd7, 0);
      run_op("divu_by0",    3'd5, 32'd5, 32'd0, 0);
      run_op("rem_by0",     3'd6, 32'd5, 32'd0, 0);
      run_op("div_neg_by0", 3'd4, 32'hFFFF_FFFB, 32'd0, 0);
      run_op("div_ovf",     3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 0);
      run_op("rem_ovf",     3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 0);
      run_op("div_by1",     3'd4, 32'hFFFF_FF00, 32'd1, 0);
      run_op("hold10",      3'd1, 32'h1234_5678, 32'h9ABC_DEF0, 10);

      // flush in the middle of CALC
      op = 3'd0; A = 32'd3; B = 32'd4; in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
      repeat (10) tick();
      flush = 1'b1;
      tick();
      flush = 1'b0;
      check("flush_calc_ready", in_ready, 1);
      check("flush_calc_result", result, last_exp);
      seen = 1'b0;
      repeat (40) begin tick(); if (out_valid) seen = 1'b1; end
      check("flush_calc_no_valid", seen, 0);

      // request presented together with flush in IDLE is dropped
      op = 3'd0; A = 32'd9; B = 32'd9; in_valid = 1'b1; flush = 1'b1;
      tick();
      in_valid = 1'b0; flush = 1'b0;
      check("flush_idle_ready", in_ready, 1);
      seen = 1'b0;
      repeat (40) begin tick(); if (out_valid) seen = 1'b1; end
      check("flush_idle_no_valid", seen, 0);

      // flush overrides the DONE handshake
      op = 3'd0; A = 32'd7; B = 32'd3; in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
      repeat (33) tick();
      check("done_valid", out_valid, 1);
      flush = 1'b1; out_ready = 1'b1;
      tick();
      flush = 1'b0; out_ready = 1'b0;
      check("flush_done_valid", out_valid, 0);
      check("flush_done_ready", in_ready, 1);
      check("flush_done_result", result, 21);

      // asynchronous reset mid-CALC
      op = 3'd4; A = 32'd1000; B = 32'd3; in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
      repeat (5) tick();
      nReset = 1'b0;
      #1;
      check("arst_ready", in_ready, 1);
      check("arst_valid", out_valid, 0);
      check("arst_result", result, 0);
      tick();
      nReset = 1'b1;
      seen = 1'b0;
      repeat (40) begin tick(); if (out_valid) seen = 1'b1; end
      check("arst_no_valid", seen, 0);

      run_op("mul_3_4", 3'd0, 32'd3, 32'd4, 0);

      for (int i = 0; i < 40; i++) begin
         run_op("rand", 3'($urandom_range(0, 7)), pick(), pick(), int'($urandom_range(0, 2)));
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
